// File: rtl/bigint_word_tx_if.sv
// Link bundle for the wide-value block-serial transmitter: wide capture side plus word stream side.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; the producer holds
// valid and its payload stable until that edge, and ready never depends combinationally on valid.
interface bigint_word_tx_if #(
  parameter int N     = 4096,
  parameter int BLOCK = 128
);
  logic [N+2:0]     in_data;
  logic             in_sign;
  logic             in_cout;
  logic             in_vld;
  logic             in_rdy;
  logic [BLOCK-1:0] out_data;
  logic [7:0]       out_idx;
  logic             out_last;
  logic             out_sign;
  logic             out_cout;
  logic             out_vld;
  logic             out_rdy;
  logic             busy;

  modport master (
    output in_data, in_sign, in_cout, in_vld, out_rdy,
    input  in_rdy, out_data, out_idx, out_last, out_sign, out_cout, out_vld, busy
  );

  modport slave (
    input  in_data, in_sign, in_cout, in_vld, out_rdy,
    output in_rdy, out_data, out_idx, out_last, out_sign, out_cout, out_vld, busy
  );
endinterface

// File: rtl/bigint_word_tx.sv
// Captures an (N+3)-bit sum with sign/carry flags and streams it LSB-first as BLOCK-bit words.
// Every output is decoded from registers only; out_rdy reaches nothing but next-state logic.
module bigint_word_tx #(
  parameter int N     = 4096,
  parameter int BLOCK = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  bigint_word_tx_if.slave      bus,
  output logic                 dbg_state_o
);
  localparam int         NWORDS   = (N + 3 + BLOCK - 1) / BLOCK;
  localparam int         SW       = NWORDS * BLOCK;
  localparam logic [7:0] LAST_IDX = 8'(NWORDS - 1);
  localparam logic [7:0] PEN_IDX  = 8'(NWORDS - 2);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e         state_q;
  logic [SW-1:0]  shreg_q;
  logic [SW-1:0]  shreg_d;
  logic [7:0]     idx_q;
  logic           last_q;
  logic           sign_q;
  logic           cout_q;

  // Zero-extended capture image; the top word carries only the leftover high bits of the sum.
  always_comb begin
    shreg_d = SW'(bus.in_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      sign_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_vld) begin
            shreg_q <= shreg_d;
            sign_q  <= bus.in_sign;
            cout_q  <= bus.in_cout;
            idx_q   <= '0;
            last_q  <= (NWORDS == 1);
            state_q <= SEND;
          end
        end
        SEND: begin
          if (bus.out_rdy) begin
            shreg_q <= shreg_q >> BLOCK;
            if (last_q) begin
              idx_q   <= '0;
              last_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + 8'd1;
              last_q  <= (idx_q == PEN_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sign/carry are left untouched on return to IDLE so the consumer can still read them.
  assign bus.in_rdy   = (state_q == IDLE);
  assign bus.busy     = (state_q == SEND);
  assign bus.out_vld  = (state_q == SEND);
  assign bus.out_data = shreg_q[BLOCK-1:0];
  assign bus.out_idx  = idx_q;
  assign bus.out_last = last_q && (idx_q == LAST_IDX);
  assign bus.out_sign = sign_q;
  assign bus.out_cout = cout_q;
  assign dbg_state_o  = logic'(state_q);
endmodule

// File: tb/tb_bigint_word_tx.sv
// Directed bench for bigint_word_tx: full-stream checks, backpressure, busy-time capture, reset abort.
module tb_bigint_word_tx;
  localparam int N      = 4096;
  localparam int BLOCK  = 128;
  localparam int NWORDS = 33;
  localparam int W      = NWORDS * BLOCK;

  logic clk;
  logic rst;
  logic dbg_state;
  int   vectors;
  int   miscompares;
  int   tn;

  bigint_word_tx_if #(.N(N), .BLOCK(BLOCK)) bus ();

  bigint_word_tx #(.N(N), .BLOCK(BLOCK)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BLOCK-1:0] obs, input logic [BLOCK-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL t%0d %s: observed %0h expected %0h", tn, tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an operand and waits for its capture edge; optionally leaves in_vld high afterwards.
  task automatic send_op(input logic [N+2:0] d, input logic s, input logic c, input bit hold);
    for (int g = 0; g < 100 && bus.in_rdy !== 1'b1; g++) tick();
    chk("in_rdy_before_capture", BLOCK'(bus.in_rdy), 1);
    bus.in_data = d;
    bus.in_sign = s;
    bus.in_cout = c;
    bus.in_vld  = 1'b1;
    tick();
    if (!hold) bus.in_vld = 1'b0;
  endtask

  // Consumes one stream, checking every beat; inj pulses a foreign operand, abort_at fires reset.
  task automatic recv(input logic [W-1:0] val, input logic s, input logic c,
                      input bit rnd, input int inj, input int abort_at);
    logic [BLOCK-1:0] exp_w;
    int guard;
    for (int i = 0; i < NWORDS; i++) begin
      exp_w = val[i*BLOCK +: BLOCK];
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_out_vld", BLOCK'(bus.out_vld), 0);
        chk("abort_busy", BLOCK'(bus.busy), 0);
        chk("abort_out_idx", BLOCK'(bus.out_idx), 0);
        chk("abort_out_sign", BLOCK'(bus.out_sign), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_rdy = 1'b0;
        tick();
        chk("post_abort_in_rdy", BLOCK'(bus.in_rdy), 1);
        return;
      end
      guard = 0;
      forever begin
        bus.out_rdy = (rnd && guard < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (i == inj) begin
          bus.in_vld  = 1'b1;
          bus.in_data = ~val[N+2:0];
          bus.in_sign = ~s;
          bus.in_cout = ~c;
        end
        chk($sformatf("out_vld_w%0d", i), BLOCK'(bus.out_vld), 1);
        chk($sformatf("busy_w%0d", i), BLOCK'(bus.busy), 1);
        chk($sformatf("in_rdy_w%0d", i), BLOCK'(bus.in_rdy), 0);
        chk($sformatf("out_data_w%0d", i), bus.out_data, exp_w);
        chk($sformatf("out_idx_w%0d", i), BLOCK'(bus.out_idx), BLOCK'(i));
        chk($sformatf("out_last_w%0d", i), BLOCK'(bus.out_last), BLOCK'(i == NWORDS - 1));
        chk($sformatf("out_sign_w%0d", i), BLOCK'(bus.out_sign), BLOCK'(s));
        chk($sformatf("out_cout_w%0d", i), BLOCK'(bus.out_cout), BLOCK'(c));
        tick();
        if (i == inj) bus.in_vld = 1'b0;
        if (bus.out_rdy) break;
        guard++;
      end
    end
    bus.out_rdy = 1'b0;
  endtask

  task automatic idle_check(input logic s, input logic c);
    chk("idle_in_rdy", BLOCK'(bus.in_rdy), 1);
    chk("idle_out_vld", BLOCK'(bus.out_vld), 0);
    chk("idle_busy", BLOCK'(bus.busy), 0);
    chk("idle_out_idx", BLOCK'(bus.out_idx), 0);
    chk("idle_out_last", BLOCK'(bus.out_last), 0);
    chk("idle_out_sign", BLOCK'(bus.out_sign), BLOCK'(s));
    chk("idle_out_cout", BLOCK'(bus.out_cout), BLOCK'(c));
  endtask

  initial begin
    logic [N+2:0] a;
    logic [N+2:0] b;
    logic [W-1:0] wide;

    vectors     = 0;
    miscompares = 0;
    tn          = 0;
    rst         = 1'b1;
    bus.in_data = '0;
    bus.in_sign = 1'b0;
    bus.in_cout = 1'b0;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    tick();
    tick();
    chk("rst_out_vld", BLOCK'(bus.out_vld), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", BLOCK'(bus.busy), 0);
    rst = 1'b0;
    tick();
    idle_check(1'b0, 1'b0);

    // 1: value 1, no backpressure
    tn = 1;
    a = '0;
    a[0] = 1'b1;
    send_op(a, 1'b0, 1'b0, 1'b0);
    recv(W'(a), 1'b0, 1'b0, 1'b0, -1, -1);
    idle_check(1'b0, 1'b0);

    // 2: all ones, flags set; top word holds only three bits
    tn = 2;
    a = '1;
    send_op(a, 1'b1, 1'b1, 1'b0);
    recv(W'(a), 1'b1, 1'b1, 1'b0, -1, -1);
    idle_check(1'b1, 1'b1);
    tick();
    chk("flags_kept_sign", BLOCK'(bus.out_sign), 1);
    chk("flags_kept_cout", BLOCK'(bus.out_cout), 1);

    // 3: word i holds i, random stalls
    tn = 3;
    wide = '0;
    for (int i = 0; i < NWORDS; i++) wide[i*BLOCK +: BLOCK] = BLOCK'(i);
    a = wide[N+2:0];
    send_op(a, 1'b0, 1'b1, 1'b0);
    recv(W'(a), 1'b0, 1'b1, 1'b1, -1, -1);
    idle_check(1'b0, 1'b1);

    // 4: foreign in_vld pulse at idx 5 is ignored
    tn = 4;
    for (int i = 0; i < NWORDS; i++) wide[i*BLOCK +: BLOCK] = {BLOCK/32{32'hA5C3_0000 + 32'(i)}};
    a = wide[N+2:0];
    send_op(a, 1'b1, 1'b0, 1'b0);
    recv(W'(a), 1'b1, 1'b0, 1'b0, 5, -1);
    idle_check(1'b1, 1'b0);
    tick();
    chk("no_capture_out_vld", BLOCK'(bus.out_vld), 0);

    // 5: reset at idx 10 drops the operand; next stream starts fresh
    tn = 5;
    send_op(a, 1'b1, 1'b1, 1'b0);
    recv(W'(a), 1'b1, 1'b1, 1'b0, -1, 10);
    b = '0;
    b[N+2:N] = 3'b101;
    b[BLOCK-1:0] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    send_op(b, 1'b0, 1'b1, 1'b0);
    recv(W'(b), 1'b0, 1'b1, 1'b0, -1, -1);
    idle_check(1'b0, 1'b1);

    // 6: back-to-back with in_vld held high
    tn = 6;
    a = '0;
    a[2*BLOCK +: BLOCK] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    b = '1;
    b[0] = 1'b0;
    send_op(a, 1'b1, 1'b0, 1'b1);
    bus.in_data = b;
    bus.in_sign = 1'b0;
    bus.in_cout = 1'b1;
    recv(W'(a), 1'b1, 1'b0, 1'b0, -1, -1);
    idle_check(1'b1, 1'b0);
    tick();
    bus.in_vld = 1'b0;
    recv(W'(b), 1'b0, 1'b1, 1'b0, -1, -1);
    idle_check(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
